cm_ahb_req_stage: RTL and testbench

CM_AHB_REQ_STAGE -- requirements
Module: cm_ahb_req_stage

---
 rtl/cm_ahb_pkg.sv | 23 ++
 rtl/cm_ahb_addr_buf.sv | 48 ++++
 rtl/cm_ahb_req_stage.sv | 152 +++++++++++++++
 tb/tb_cm_ahb_req_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cm_ahb_pkg.sv
// Shared AHB encodings and request-stage FSM state type.
package cm_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_OWN  = 2'd2
  } req_state_e;

  // A replayed beat starts a fresh burst after arbitration, so SEQ must become NONSEQ.
  function automatic logic [1:0] fwd_trans(input logic [1:0] t);
    return (t == HTRANS_SEQ) ? HTRANS_NONSEQ : t;
  endfunction

endpackage

// File: rtl/cm_ahb_addr_buf.sv
// One-entry AHB address-phase holding register; load wins over clear.
module cm_ahb_addr_buf
  import cm_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      haddr_o  <= '0;
      htrans_o <= HTRANS_IDLE;
      hwrite_o <= 1'b0;
      hsize_o  <= '0;
      hburst_o <= '0;
      hprot_o  <= '0;
    end else if (load_i) begin
      valid_o  <= 1'b1;
      haddr_o  <= haddr_i;
      htrans_o <= htrans_i;
      hwrite_o <= hwrite_i;
      hsize_o  <= hsize_i;
      hburst_o <= hburst_i;
      hprot_o  <= hprot_i;
    end else if (clear_i) begin
      valid_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/cm_ahb_req_stage.sv
// AHB master-side request stage: buffers one address phase until the slave-port arbiter grants.
//   state   | meaning
//   ST_IDLE | no ownership, buffer empty
//   ST_PEND | one phase buffered, requesting
//   ST_OWN  | port granted, master address phase passes straight through
module cm_ahb_req_stage
  import cm_ahb_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   PRI_WIDTH  = 1,
  parameter logic [PRI_WIDTH-1:0] PRI_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic                  req,
  output logic [PRI_WIDTH-1:0]  pri,
  input  logic                  gnt,
  output logic [ADDR_WIDTH-1:0] m_haddr,
  output logic [1:0]            m_htrans,
  output logic                  m_hwrite,
  output logic [2:0]            m_hsize,
  output logic [2:0]            m_hburst,
  output logic [3:0]            m_hprot,
  input  logic                  m_hready,
  input  logic                  m_hresp
);

  req_state_e            state_q, state_d;
  logic                  dp_q, dp_d;
  logic [ADDR_WIDTH-1:0] m_haddr_q;
  logic                  m_hwrite_q;
  logic [2:0]            m_hsize_q, m_hburst_q;
  logic [3:0]            m_hprot_q;

  logic                  buf_load, buf_clear, b_valid, b_hwrite;
  logic [ADDR_WIDTH-1:0] b_haddr;
  logic [1:0]            b_htrans;
  logic [2:0]            b_hsize, b_hburst;
  logic [3:0]            b_hprot;

  logic addr_vld, mst_active;

  assign addr_vld   = hsel & htrans[1] & hready;
  assign mst_active = hsel & (htrans != HTRANS_IDLE);

  cm_ahb_addr_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (buf_load),
    .clear_i  (buf_clear),
    .haddr_i  (haddr),
    .htrans_i (htrans),
    .hwrite_i (hwrite),
    .hsize_i  (hsize),
    .hburst_i (hburst),
    .hprot_i  (hprot),
    .valid_o  (b_valid),
    .haddr_o  (b_haddr),
    .htrans_o (b_htrans),
    .hwrite_o (b_hwrite),
    .hsize_o  (b_hsize),
    .hburst_o (b_hburst),
    .hprot_o  (b_hprot)
  );

  always_comb begin
    state_d   = state_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    req       = 1'b0;
    m_htrans  = HTRANS_IDLE;
    m_haddr   = m_haddr_q;
    m_hwrite  = m_hwrite_q;
    m_hsize   = m_hsize_q;
    m_hburst  = m_hburst_q;
    m_hprot   = m_hprot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (addr_vld) begin
          buf_load = 1'b1;
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        req = 1'b1;
        if (gnt) begin
          buf_clear = 1'b1;
          state_d   = ST_OWN;
          m_htrans  = fwd_trans(b_htrans);
          m_haddr   = b_haddr;
          m_hwrite  = b_hwrite;
          m_hsize   = b_hsize;
          m_hburst  = b_hburst;
          m_hprot   = b_hprot;
        end
      end
      ST_OWN: begin
        req      = mst_active | dp_q;
        m_htrans = hsel ? htrans : HTRANS_IDLE;
        m_haddr  = haddr;
        m_hwrite = hwrite;
        m_hsize  = hsize;
        m_hburst = hburst;
        m_hprot  = hprot;
        // Losing the grant while the master issues: park that phase for replay.
        if (!gnt && addr_vld) begin
          buf_load = 1'b1;
          state_d  = ST_PEND;
        end else if (gnt && !mst_active && !b_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dp_d      = m_hready ? (gnt & m_htrans[1]) : dp_q;
  assign hreadyout = dp_q ? m_hready : ~b_valid;
  assign hresp     = dp_q ? m_hresp : HRESP_OKAY;
  assign pri       = PRI_VALUE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dp_q       <= 1'b0;
      m_haddr_q  <= '0;
      m_hwrite_q <= 1'b0;
      m_hsize_q  <= '0;
      m_hburst_q <= '0;
      m_hprot_q  <= '0;
    end else begin
      state_q    <= state_d;
      dp_q       <= dp_d;
      m_haddr_q  <= m_haddr;
      m_hwrite_q <= m_hwrite;
      m_hsize_q  <= m_hsize;
      m_hburst_q <= m_hburst;
      m_hprot_q  <= m_hprot;
    end
  end

endmodule

// File: tb/tb_cm_ahb_req_stage.sv
// Directed bench for cm_ahb_req_stage; bus hready is looped back from hreadyout.
module tb_cm_ahb_req_stage;
  import cm_ahb_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel, hwrite, hready, hreadyout, hresp, req, gnt;
  logic [AW-1:0] haddr, m_haddr;
  logic [1:0]    htrans, m_htrans, pri;
  logic [2:0]    hsize, hburst, m_hsize, m_hburst;
  logic [3:0]    hprot, m_hprot;
  logic          m_hwrite, m_hready, m_hresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  cm_ahb_req_stage #(.ADDR_WIDTH(AW), .PRI_WIDTH(2), .PRI_VALUE(2'd2)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .req(req), .pri(pri), .gnt(gnt),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hready(m_hready), .m_hresp(m_hresp)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, let combinational outputs settle.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic g, input logic mr, input logic me);
    @(negedge clk);
    hsel = sel; htrans = tr; haddr = a;
    gnt = g; m_hready = mr; m_hresp = me;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3;
    gnt = 1'b0; m_hready = 1'b1; m_hresp = 1'b0;
    #2;
    chk("rst_req", req, 0);
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_m_htrans", m_htrans, HTRANS_IDLE);
    chk("rst_m_haddr", m_haddr, 0);
    chk("rst_m_hprot", m_hprot, 0);
    chk("rst_m_hsize", m_hsize, 0);
    chk("pri", pri, 2);
    @(negedge clk);
    rst_n = 1'b1;

    // Uncontended single write
    hwrite = 1'b1;
    cyc(1, HTRANS_NONSEQ, 32'h1000, 0, 1, 0);
    chk("s1_idle_hreadyout", hreadyout, 1);
    chk("s1_idle_req", req, 0);
    chk("s1_idle_m_htrans", m_htrans, HTRANS_IDLE);
    cyc(0, HTRANS_IDLE, 32'h1000, 1, 1, 0);
    chk("s1_fwd_hreadyout", hreadyout, 0);
    chk("s1_fwd_req", req, 1);
    chk("s1_fwd_m_htrans", m_htrans, HTRANS_NONSEQ);
    chk("s1_fwd_m_haddr", m_haddr, 32'h1000);
    chk("s1_fwd_m_hwrite", m_hwrite, 1);
    cyc(0, HTRANS_IDLE, 32'h1000, 0, 0, 0);
    chk("s1_wait_hreadyout", hreadyout, 0);
    chk("s1_wait_req", req, 1);
    chk("s1_wait_m_htrans", m_htrans, HTRANS_IDLE);
    cyc(0, HTRANS_IDLE, 32'h1000, 1, 1, 0);
    chk("s1_done_hreadyout", hreadyout, 1);
    chk("s1_done_req", req, 1);
    cyc(1, HTRANS_BUSY, 32'h1000, 0, 1, 0);
    chk("s1_back_req", req, 0);
    chk("s1_back_m_htrans", m_htrans, HTRANS_IDLE);
    chk("s1_hold_m_haddr", m_haddr, 32'h1000);
    cyc(0, HTRANS_IDLE, 32'h1000, 0, 1, 0);
    chk("busy_not_buf_req", req, 0);
    chk("busy_not_buf_hreadyout", hreadyout, 1);

    // Blocked grant
    hwrite = 1'b0;
    cyc(1, HTRANS_NONSEQ, 32'h1100, 0, 1, 0);
    chk("s2_req0", req, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, HTRANS_IDLE, 32'h1100, 0, 1, 0);
      chk("s2_blk_req", req, 1);
      chk("s2_blk_hreadyout", hreadyout, 0);
      chk("s2_blk_m_htrans", m_htrans, HTRANS_IDLE);
      chk("s2_blk_m_haddr_hold", m_haddr, 32'h1000);
    end
    cyc(0, HTRANS_IDLE, 32'h1100, 1, 1, 0);
    chk("s2_fwd_m_htrans", m_htrans, HTRANS_NONSEQ);
    chk("s2_fwd_m_haddr", m_haddr, 32'h1100);
    chk("s2_fwd_m_hwrite", m_hwrite, 0);
    chk("s2_fwd_hreadyout", hreadyout, 0);
    cyc(0, HTRANS_IDLE, 32'h1100, 1, 1, 0);
    chk("s2_dp_hreadyout", hreadyout, 1);
    chk("s2_dp_req", req, 1);
    cyc(0, HTRANS_IDLE, 32'h1100, 0, 1, 0);
    chk("s2_end_req", req, 0);

    // INCR4 in OWN with a BUSY beat
    hburst = 3'b011;
    cyc(1, HTRANS_NONSEQ, 32'h2000, 0, 1, 0);
    cyc(1, HTRANS_SEQ, 32'h2004, 1, 1, 0);
    chk("s3_fwd_m_htrans", m_htrans, HTRANS_NONSEQ);
    chk("s3_fwd_m_haddr", m_haddr, 32'h2000);
    chk("s3_fwd_m_hburst", m_hburst, 3'b011);
    chk("s3_fwd_hreadyout", hreadyout, 0);
    cyc(1, HTRANS_SEQ, 32'h2004, 1, 1, 0);
    chk("s3_b2_m_htrans", m_htrans, HTRANS_SEQ);
    chk("s3_b2_m_haddr", m_haddr, 32'h2004);
    chk("s3_b2_hreadyout", hreadyout, 1);
    chk("s3_b2_req", req, 1);
    cyc(1, HTRANS_BUSY, 32'h2008, 1, 1, 0);
    chk("s3_busy_m_htrans", m_htrans, HTRANS_BUSY);
    chk("s3_busy_req", req, 1);
    cyc(1, HTRANS_SEQ, 32'h2008, 1, 1, 1);
    chk("s3_busy_no_dp_hresp", hresp, 0);
    chk("s3_b3_m_haddr", m_haddr, 32'h2008);
    chk("s3_b3_m_htrans", m_htrans, HTRANS_SEQ);
    cyc(1, HTRANS_SEQ, 32'h200C, 1, 1, 0);
    chk("s3_b4_m_haddr", m_haddr, 32'h200C);
    cyc(1, HTRANS_IDLE, 32'h200C, 0, 0, 0);
    chk("s3_last_wait_hreadyout", hreadyout, 0);
    chk("s3_last_wait_req", req, 1);
    chk("s3_last_m_htrans", m_htrans, HTRANS_IDLE);
    cyc(1, HTRANS_IDLE, 32'h200C, 1, 1, 0);
    chk("s3_last_done_hreadyout", hreadyout, 1);
    chk("s3_last_done_req", req, 1);
    cyc(0, HTRANS_IDLE, 32'h200C, 0, 1, 0);
    chk("s3_end_req", req, 0);

    // Preemption on beat 3 and replay as NONSEQ
    cyc(1, HTRANS_NONSEQ, 32'h2000, 0, 1, 0);
    cyc(1, HTRANS_SEQ, 32'h2004, 1, 1, 0);
    cyc(1, HTRANS_SEQ, 32'h2004, 1, 1, 0);
    cyc(1, HTRANS_SEQ, 32'h2008, 0, 1, 0);
    chk("s4_pre_hreadyout", hreadyout, 1);
    chk("s4_pre_req", req, 1);
    cyc(1, HTRANS_SEQ, 32'h200C, 0, 1, 0);
    chk("s4_pend_hreadyout", hreadyout, 0);
    chk("s4_pend_req", req, 1);
    chk("s4_pend_m_htrans", m_htrans, HTRANS_IDLE);
    cyc(1, HTRANS_SEQ, 32'h200C, 1, 1, 0);
    chk("s4_replay_m_htrans", m_htrans, HTRANS_NONSEQ);
    chk("s4_replay_m_haddr", m_haddr, 32'h2008);
    chk("s4_replay_hreadyout", hreadyout, 0);
    cyc(1, HTRANS_SEQ, 32'h200C, 1, 1, 0);
    chk("s4_b4_m_htrans", m_htrans, HTRANS_SEQ);
    chk("s4_b4_m_haddr", m_haddr, 32'h200C);
    chk("s4_b4_hreadyout", hreadyout, 1);
    cyc(1, HTRANS_IDLE, 32'h200C, 1, 1, 0);
    chk("s4_last_req", req, 1);
    cyc(0, HTRANS_IDLE, 32'h200C, 0, 1, 0);
    chk("s4_end_req", req, 0);

    // Two-cycle ERROR response
    hburst = 3'd0;
    cyc(1, HTRANS_NONSEQ, 32'h3000, 0, 1, 0);
    cyc(0, HTRANS_IDLE, 32'h3000, 1, 1, 0);
    cyc(0, HTRANS_IDLE, 32'h3000, 0, 0, 1);
    chk("s5_err1_hresp", hresp, 1);
    chk("s5_err1_hreadyout", hreadyout, 0);
    cyc(0, HTRANS_IDLE, 32'h3000, 1, 1, 1);
    chk("s5_err2_hresp", hresp, 1);
    chk("s5_err2_hreadyout", hreadyout, 1);
    cyc(0, HTRANS_IDLE, 32'h3000, 0, 1, 1);
    chk("s5_no_dp_hresp", hresp, 0);
    chk("s5_no_dp_hreadyout", hreadyout, 1);

    // Reset while PEND, no replay afterwards
    cyc(1, HTRANS_NONSEQ, 32'h4000, 0, 1, 0);
    cyc(0, HTRANS_IDLE, 32'h4000, 0, 1, 0);
    chk("s6_pend_req", req, 1);
    chk("s6_pend_hreadyout", hreadyout, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_req", req, 0);
    chk("s6_rst_hreadyout", hreadyout, 1);
    chk("s6_rst_m_htrans", m_htrans, HTRANS_IDLE);
    chk("s6_rst_m_haddr", m_haddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(0, HTRANS_IDLE, 32'h4000, 1, 1, 0);
      chk("s6_post_req", req, 0);
      chk("s6_post_m_htrans", m_htrans, HTRANS_IDLE);
      chk("s6_post_hreadyout", hreadyout, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
